// File: rtl/vga_scan_controller.sv
// 640x480@60 VGA scan generator: raw pixel counters toward the framebuffer,
// colour expansion of the returned pixel, and sync/blank aligned to its read latency.
module vga_scan_controller #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter logic        SYNC_ACTIVE  = 1'b0,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic       clock_video,
  input  logic       reset,
  output logic [9:0] pixel_x_pos,
  output logic [9:0] pixel_y_pos,
  input  logic [7:0] pixel_frame0,
  input  logic [7:0] pixel_frame1,
  input  logic       frame_select,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [3:0] vga_red,
  output logic [3:0] vga_green,
  output logic [3:0] vga_blue,
  output logic       frame_start,
  output logic       vblank
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic                    h_last;
  logic                    v_last;
  logic                    active;
  logic                    hs;
  logic                    vs;
  logic                    shown_frame;
  logic [7:0]              pixel;
  logic [READ_LATENCY-1:0] active_pipe;
  logic [READ_LATENCY-1:0] hs_pipe;
  logic [READ_LATENCY-1:0] vs_pipe;

  // Counter-domain decode and frame mux
  always_comb begin
    h_last = (pixel_x_pos == 10'(H_TOTAL - 1));
    v_last = (pixel_y_pos == 10'(V_TOTAL - 1));
    active = (pixel_x_pos < 10'(H_ACTIVE)) && (pixel_y_pos < 10'(V_ACTIVE));
    hs     = (pixel_x_pos >= 10'(HS_START)) && (pixel_x_pos < 10'(HS_END));
    vs     = (pixel_y_pos >= 10'(VS_START)) && (pixel_y_pos < 10'(VS_END));
    pixel  = shown_frame ? pixel_frame1 : pixel_frame0;
  end

  // Scan counters
  always_ff @(posedge clock_video) begin
    if (reset) begin
      pixel_x_pos <= '0;
      pixel_y_pos <= '0;
    end else if (h_last) begin
      pixel_x_pos <= '0;
      pixel_y_pos <= v_last ? '0 : pixel_y_pos + 10'd1;
    end else begin
      pixel_x_pos <= pixel_x_pos + 10'd1;
    end
  end

  // Displayed frame only changes at the frame wrap so a swap never tears
  always_ff @(posedge clock_video) begin
    if (reset) begin
      shown_frame <= 1'b0;
    end else if (h_last && v_last) begin
      shown_frame <= frame_select;
    end
  end

  // Delay line matching the framebuffer read latency
  always_ff @(posedge clock_video) begin
    if (reset) begin
      active_pipe <= '0;
      hs_pipe     <= '0;
      vs_pipe     <= '0;
    end else begin
      active_pipe[0] <= active;
      hs_pipe[0]     <= hs;
      vs_pipe[0]     <= vs;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        active_pipe[i] <= active_pipe[i-1];
        hs_pipe[i]     <= hs_pipe[i-1];
        vs_pipe[i]     <= vs_pipe[i-1];
      end
    end
  end

  // Pin registers; frame_start/vblank are sampled from the counters, one clock behind them
  always_ff @(posedge clock_video) begin
    if (reset) begin
      vga_hsync   <= ~SYNC_ACTIVE;
      vga_vsync   <= ~SYNC_ACTIVE;
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      vga_hsync   <= hs_pipe[READ_LATENCY-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vga_vsync   <= vs_pipe[READ_LATENCY-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start <= (pixel_x_pos == '0) && (pixel_y_pos == '0);
      vblank      <= (pixel_y_pos >= 10'(V_ACTIVE));
      if (active_pipe[READ_LATENCY-1]) begin
        vga_red   <= {pixel[2:0], pixel[2]};
        vga_green <= {pixel[5:3], pixel[5]};
        vga_blue  <= {pixel[7:6], pixel[7:6]};
      end else begin
        vga_red   <= '0;
        vga_green <= '0;
        vga_blue  <= '0;
      end
    end
  end

endmodule
